// File: rtl/lcd_id_probe_ctrl.sv
// rtl/lcd_id_probe_ctrl.sv - LCD panel-ID probe sequencer: release bus, settle, sample strap code, decode timing
module lcd_id_probe_ctrl #(
  parameter int SETTLE_CYC  = 1000,
  parameter int SAMPLE_GAP  = 50,
  parameter int MATCH_N     = 3,
  parameter int MAX_SAMPLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        probe_req,
  input  logic [23:0] lcd_rgb_in,
  output logic        lcd_rgb_oe,
  output logic        disp_en,
  output logic        busy,
  output logic        id_valid,
  output logic        id_err,
  output logic [15:0] id_lcd,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic [1:0]  clk_sel
);

  // Widths hold the terminal value itself, so a parameter of 1 still gets a 1-bit counter.
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int GW = $clog2(SAMPLE_GAP + 1);
  localparam int MW = $clog2(MATCH_N + 1);
  localparam int NW = $clog2(MAX_SAMPLES + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(SAMPLE_GAP - 1);
  localparam logic [MW-1:0] MATCH_DONE  = MW'(MATCH_N);
  localparam logic [NW-1:0] SAMPLE_DONE = NW'(MAX_SAMPLES);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DECODE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  logic [NW-1:0] sample_cnt_q, sample_cnt_d;
  logic [2:0]    code_q, code_d;
  logic          timeout_q, timeout_d;

  logic          lcd_rgb_oe_q, lcd_rgb_oe_d;
  logic          disp_en_q, disp_en_d;
  logic          busy_q, busy_d;
  logic          id_valid_q, id_valid_d;
  logic          id_err_q, id_err_d;
  logic [15:0]   id_lcd_q, id_lcd_d;
  logic [10:0]   h_disp_q, h_disp_d;
  logic [10:0]   v_disp_q, v_disp_d;
  logic [1:0]    clk_sel_q, clk_sel_d;

  logic [2:0]    code_in;
  logic [MW-1:0] match_next;
  logic [NW-1:0] sample_next;

  // Only the three strap bits matter; the rest of the bus is intentionally ignored.
  logic unused_rgb_bits;
  assign unused_rgb_bits = ^{lcd_rgb_in[22:16], lcd_rgb_in[14:8], lcd_rgb_in[6:0]};

  assign code_in = {lcd_rgb_in[7], lcd_rgb_in[15], lcd_rgb_in[23]};

  // Next-state, counter and output computation for the probe sequence.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    match_cnt_d  = match_cnt_q;
    sample_cnt_d = sample_cnt_q;
    code_d       = code_q;
    timeout_d    = timeout_q;
    lcd_rgb_oe_d = lcd_rgb_oe_q;
    disp_en_d    = disp_en_q;
    busy_d       = busy_q;
    id_valid_d   = id_valid_q;
    id_err_d     = id_err_q;
    id_lcd_d     = id_lcd_q;
    h_disp_d     = h_disp_q;
    v_disp_d     = v_disp_q;
    clk_sel_d    = clk_sel_q;
    match_next   = match_cnt_q;
    sample_next  = sample_cnt_q + NW'(1);

    case (state_q)
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d      = ST_SAMPLE;
          settle_cnt_d = '0;
          gap_cnt_d    = '0;
          match_cnt_d  = '0;
          sample_cnt_d = '0;
          timeout_d    = 1'b0;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end

      ST_SAMPLE: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          code_d    = code_in;
          // A zero match count means no previous capture exists in this probe.
          if (match_cnt_q != '0 && code_in == code_q) begin
            match_next = match_cnt_q + MW'(1);
          end else begin
            match_next = MW'(1);
          end
          match_cnt_d  = match_next;
          sample_cnt_d = sample_next;
          // A match on the final allowed sample still counts as a match.
          if (match_next == MATCH_DONE) begin
            state_d   = ST_DECODE;
            timeout_d = 1'b0;
          end else if (sample_next == SAMPLE_DONE) begin
            state_d   = ST_DECODE;
            timeout_d = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      ST_DECODE: begin
        state_d      = ST_DONE;
        lcd_rgb_oe_d = 1'b1;
        disp_en_d    = 1'b1;
        id_valid_d   = 1'b1;
        busy_d       = 1'b0;
        id_err_d     = 1'b0;
        case (code_q)
          3'b000:  begin id_lcd_d = 16'h4342; h_disp_d = 11'd480;  v_disp_d = 11'd272; clk_sel_d = 2'd0; end
          3'b001:  begin id_lcd_d = 16'h7084; h_disp_d = 11'd800;  v_disp_d = 11'd480; clk_sel_d = 2'd1; end
          3'b010:  begin id_lcd_d = 16'h7016; h_disp_d = 11'd1024; v_disp_d = 11'd600; clk_sel_d = 2'd2; end
          3'b100:  begin id_lcd_d = 16'h4384; h_disp_d = 11'd800;  v_disp_d = 11'd480; clk_sel_d = 2'd1; end
          3'b101:  begin id_lcd_d = 16'h1018; h_disp_d = 11'd1280; v_disp_d = 11'd800; clk_sel_d = 2'd3; end
          default: begin id_lcd_d = 16'h4342; h_disp_d = 11'd480;  v_disp_d = 11'd272; clk_sel_d = 2'd0; id_err_d = 1'b1; end
        endcase
        // Timeout overrides whatever code happened to be captured last.
        if (timeout_q) begin
          id_lcd_d  = 16'h4342;
          h_disp_d  = 11'd480;
          v_disp_d  = 11'd272;
          clk_sel_d = 2'd0;
          id_err_d  = 1'b1;
        end
      end

      ST_DONE: begin
        // Decoded outputs are left untouched so they hold until the next decode.
        if (probe_req) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
          gap_cnt_d    = '0;
          match_cnt_d  = '0;
          sample_cnt_d = '0;
          timeout_d    = 1'b0;
          lcd_rgb_oe_d = 1'b0;
          disp_en_d    = 1'b0;
          id_valid_d   = 1'b0;
          busy_d       = 1'b1;
        end
      end

      default: begin
        state_d = ST_SETTLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset restarts the probe from settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SETTLE;
      settle_cnt_q <= '0;
      gap_cnt_q    <= '0;
      match_cnt_q  <= '0;
      sample_cnt_q <= '0;
      code_q       <= '0;
      timeout_q    <= 1'b0;
      lcd_rgb_oe_q <= 1'b0;
      disp_en_q    <= 1'b0;
      busy_q       <= 1'b1;
      id_valid_q   <= 1'b0;
      id_err_q     <= 1'b0;
      id_lcd_q     <= 16'h0000;
      h_disp_q     <= '0;
      v_disp_q     <= '0;
      clk_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      match_cnt_q  <= match_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      code_q       <= code_d;
      timeout_q    <= timeout_d;
      lcd_rgb_oe_q <= lcd_rgb_oe_d;
      disp_en_q    <= disp_en_d;
      busy_q       <= busy_d;
      id_valid_q   <= id_valid_d;
      id_err_q     <= id_err_d;
      id_lcd_q     <= id_lcd_d;
      h_disp_q     <= h_disp_d;
      v_disp_q     <= v_disp_d;
      clk_sel_q    <= clk_sel_d;
    end
  end

  assign lcd_rgb_oe = lcd_rgb_oe_q;
  assign disp_en    = disp_en_q;
  assign busy       = busy_q;
  assign id_valid   = id_valid_q;
  assign id_err     = id_err_q;
  assign id_lcd     = id_lcd_q;
  assign h_disp     = h_disp_q;
  assign v_disp     = v_disp_q;
  assign clk_sel    = clk_sel_q;

endmodule

// File: tb/tb_lcd_id_probe_ctrl.sv
// tb/tb_lcd_id_probe_ctrl.sv - self-checking bench for lcd_id_probe_ctrl against a sample-sequence model
module tb_lcd_id_probe_ctrl;

  localparam int SETTLE = 8;
  localparam int GAP    = 2;
  localparam int MATCHN = 3;
  localparam int MAXS   = 8;

  logic        clk;
  logic        rst;
  logic        probe_req;
  logic [23:0] lcd_rgb_in;
  logic        lcd_rgb_oe;
  logic        disp_en;
  logic        busy;
  logic        id_valid;
  logic        id_err;
  logic [15:0] id_lcd;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic [1:0]  clk_sel;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]  seq [1:MAXS];
  logic [15:0] exp_lcd;
  logic [10:0] exp_h, exp_v;
  logic [1:0]  exp_sel;
  logic        exp_err;

  lcd_id_probe_ctrl #(
    .SETTLE_CYC(SETTLE), .SAMPLE_GAP(GAP), .MATCH_N(MATCHN), .MAX_SAMPLES(MAXS)
  ) dut (
    .clk(clk), .rst(rst), .probe_req(probe_req), .lcd_rgb_in(lcd_rgb_in),
    .lcd_rgb_oe(lcd_rgb_oe), .disp_en(disp_en), .busy(busy), .id_valid(id_valid),
    .id_err(id_err), .id_lcd(id_lcd), .h_disp(h_disp), .v_disp(v_disp), .clk_sel(clk_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " oe"},       32'(lcd_rgb_oe), 32'd0);
    check({tag, " disp_en"},  32'(disp_en),    32'd0);
    check({tag, " busy"},     32'(busy),       32'd1);
    check({tag, " id_valid"}, 32'(id_valid),   32'd0);
    check({tag, " id_err"},   32'(id_err),     32'd0);
    check({tag, " id_lcd"},   32'(id_lcd),     32'd0);
    check({tag, " h_disp"},   32'(h_disp),     32'd0);
    check({tag, " v_disp"},   32'(v_disp),     32'd0);
    check({tag, " clk_sel"},  32'(clk_sel),    32'd0);
  endtask

  // Panel table: known codes map to their timing, anything else falls back with an error.
  task automatic table_lookup(input logic [2:0] c, input bit timed_out);
    exp_err = 1'b0;
    case (c)
      3'b001:  begin exp_lcd = 16'h7084; exp_h = 11'd800;  exp_v = 11'd480; exp_sel = 2'd1; end
      3'b010:  begin exp_lcd = 16'h7016; exp_h = 11'd1024; exp_v = 11'd600; exp_sel = 2'd2; end
      3'b100:  begin exp_lcd = 16'h4384; exp_h = 11'd800;  exp_v = 11'd480; exp_sel = 2'd1; end
      3'b101:  begin exp_lcd = 16'h1018; exp_h = 11'd1280; exp_v = 11'd800; exp_sel = 2'd3; end
      default: begin exp_lcd = 16'h4342; exp_h = 11'd480;  exp_v = 11'd272; exp_sel = 2'd0; end
    endcase
    if (c == 3'b011 || c == 3'b110 || c == 3'b111 || timed_out) begin
      exp_lcd = 16'h4342; exp_h = 11'd480; exp_v = 11'd272; exp_sel = 2'd0; exp_err = 1'b1;
    end
  endtask

  // Starts just after a rising edge with the DUT at the start of settle.
  // abort_at > 0 asserts rst in the middle of that cycle and returns.
  task automatic run_probe(input string name, input int abort_at, input bit extra_req);
    int          run_len;
    int          k_done;
    bit          timed_out;
    logic [2:0]  last;
    int          exp_edge;
    int          idx;
    logic [23:0] rgb;

    run_len = 0;
    k_done = MAXS;
    timed_out = 1'b1;
    last = 3'b000;
    for (int k = 1; k <= MAXS; k++) begin
      run_len = (run_len > 0 && seq[k] == last) ? run_len + 1 : 1;
      last = seq[k];
      if (run_len == MATCHN) begin
        k_done = k;
        timed_out = 1'b0;
        break;
      end
    end
    exp_edge = SETTLE + k_done * GAP + 1;

    for (int n = 1; n <= exp_edge; n++) begin
      @(negedge clk);
      if (n <= SETTLE) idx = 1;
      else idx = (n - SETTLE + GAP - 1) / GAP;
      if (idx > MAXS) idx = MAXS;
      rgb = 24'($urandom);
      rgb[7]  = seq[idx][2];
      rgb[15] = seq[idx][1];
      rgb[23] = seq[idx][0];
      lcd_rgb_in = rgb;
      probe_req = (extra_req && n == 5);
      if (n == abort_at) begin
        probe_req = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_values({name, " async rst"});
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (n == exp_edge - 1) begin
        check({name, " valid early"},   32'(id_valid),   32'd0);
        check({name, " oe early"},      32'(lcd_rgb_oe), 32'd0);
        check({name, " disp_en early"}, 32'(disp_en),    32'd0);
        check({name, " busy early"},    32'(busy),       32'd1);
      end
    end

    table_lookup(last, timed_out);
    check({name, " id_valid"}, 32'(id_valid),   32'd1);
    check({name, " oe"},       32'(lcd_rgb_oe), 32'd1);
    check({name, " disp_en"},  32'(disp_en),    32'd1);
    check({name, " busy"},     32'(busy),       32'd0);
    check({name, " id_lcd"},   32'(id_lcd),     32'(exp_lcd));
    check({name, " h_disp"},   32'(h_disp),     32'(exp_h));
    check({name, " v_disp"},   32'(v_disp),     32'(exp_v));
    check({name, " clk_sel"},  32'(clk_sel),    32'(exp_sel));
    check({name, " id_err"},   32'(id_err),     32'(exp_err));
  endtask

  // From DONE: request a re-probe, confirm the drop and hold, then run the new probe.
  task automatic reprobe(input string name, input bit extra_req);
    @(negedge clk);
    probe_req = 1'b1;
    @(posedge clk);
    #1;
    probe_req = 1'b0;
    check({name, " drop valid"},   32'(id_valid),   32'd0);
    check({name, " drop oe"},      32'(lcd_rgb_oe), 32'd0);
    check({name, " drop disp_en"}, 32'(disp_en),    32'd0);
    check({name, " busy set"},     32'(busy),       32'd1);
    check({name, " hold id_lcd"},  32'(id_lcd),     32'(exp_lcd));
    check({name, " hold h_disp"},  32'(h_disp),     32'(exp_h));
    check({name, " hold id_err"},  32'(id_err),     32'(exp_err));
    run_probe(name, 0, extra_req);
  endtask

  task automatic fill(input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] a3, input logic [2:0] a4,
                      input logic [2:0] a5, input logic [2:0] a6, input logic [2:0] a7, input logic [2:0] a8);
    seq[1] = a1; seq[2] = a2; seq[3] = a3; seq[4] = a4;
    seq[5] = a5; seq[6] = a6; seq[7] = a7; seq[8] = a8;
  endtask

  initial begin
    rst = 1'b1;
    probe_req = 1'b0;
    lcd_rgb_in = '0;
    #23;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    fill(3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001);
    run_probe("static001", 0, 1'b0);

    // Stay in DONE a few cycles: outputs must hold with no request.
    repeat (3) @(posedge clk);
    #1;
    check("done hold valid", 32'(id_valid), 32'd1);

    fill(3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010);
    reprobe("reprobe010", 1'b1);

    fill(3'b101, 3'b000, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b101);
    reprobe("toggle101", 1'b0);

    fill(3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001);
    reprobe("timeout", 1'b0);

    fill(3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111);
    reprobe("static111", 1'b0);

    fill(3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b100, 3'b100, 3'b100);
    reprobe("code100", 1'b0);

    // Match completes exactly on the last permitted sample.
    fill(3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010);
    reprobe("match_last", 1'b0);

    // Reset mid-sample, then a full-latency probe from release.
    fill(3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001);
    @(negedge clk);
    probe_req = 1'b1;
    @(posedge clk);
    #1;
    probe_req = 1'b0;
    run_probe("mid_rst", 11, 1'b0);
    run_probe("after_rst", 0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      seq[1] = 3'($urandom);
      for (int k = 2; k <= MAXS; k++)
        seq[k] = ($urandom_range(0, 2) == 0) ? 3'($urandom) : seq[k-1];
      reprobe($sformatf("rand%0d", r), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_id_probe_ctrl.md
# lcd_id_probe_ctrl

- Sequences the panel-ID probe of the RGB LCD interface at power-up and on request:
  - releases the RGB bus;
  - waits for the panel strap pins to settle;
  - samples the 3-bit ID code on `lcd_rgb[23]`, `[15]` and `[7]` until it is stable;
  - decodes it to a panel ID and display-timing selection.
- Sits between the LCD pin drivers and the LCD timing generator/pixel-clock divider. The timing generator must not drive the bus until `disp_en` is high.

## Interface
- `SETTLE_CYC`, 1000: cycles from bus release to the first sample window.
- `SAMPLE_GAP`, 50: cycles between successive samples.
- `MATCH_N`, 3: consecutive identical samples required to accept a code.
- `MAX_SAMPLES`, 16: sample limit before fallback.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `probe_req` in 1: one-cycle pulse requesting a re-probe.
- `lcd_rgb_in` in 24: RGB pad inputs.
- `lcd_rgb_oe` out 1: 1 = pixel data may drive the pads; 0 = pads released.
- `disp_en` out 1: enables the timing generator.
- `busy` out 1: probe in progress.
- `id_valid` out 1: decoded outputs valid.
- `id_err` out 1: no stable or known code; fallback applied.
- `id_lcd` out 16: panel ID.
- `h_disp` out 11: active pixels per line.
- `v_disp` out 11: active lines.
- `clk_sel` out 2: pixel-clock divider select.

## Operation
- Code: `code = {lcd_rgb_in[7], lcd_rgb_in[15], lcd_rgb_in[23]}`, sampled only in state SAMPLE.
- FSM states:
  - **SETTLE:** `oe=0`, `busy=1`. Counter runs 0..SETTLE_CYC-1, then go to SAMPLE. Gap counter and match counter clear on entry.
  - **SAMPLE:** gap counter runs 0..SAMPLE_GAP-1. When it reaches SAMPLE_GAP-1:
    - capture `code`;
    - if `code` equals the previous capture, `match_cnt++`; otherwise `match_cnt=1`;
    - `sample_cnt++`.
  - **SAMPLE exits:**
    - `match_cnt` reaches MATCH_N → DECODE with the captured code.
    - Otherwise, `sample_cnt` reaches MAX_SAMPLES → DECODE with `err=1`.
    - If both happen on the same sample, the match wins.
  - **DECODE:** one cycle. Registers `id_lcd`, `h_disp`, `v_disp`, `clk_sel` and `id_err`, then goes to DONE.
  - **DONE:** `oe=1`, `disp_en=1`, `id_valid=1`, `busy=0`. A `probe_req` pulse goes to SETTLE.
- Decode (code → `id_lcd`, `h_disp`×`v_disp`, `clk_sel`):
  - 000 → 0x4342, 480×272, 0
  - 001 → 0x7084, 800×480, 1
  - 010 → 0x7016, 1024×600, 2
  - 100 → 0x4384, 800×480, 1
  - 101 → 0x1018, 1280×800, 3
- Fallback: codes 011, 110, 111, or a timeout, decode as 0x4342 / 480×272 / 0 with `id_err=1`. A successful known decode clears `id_err`.
- `probe_req`: ignored outside DONE. In DONE it is taken on the same edge.
- Re-probe:
  - `id_valid`, `disp_en` and `lcd_rgb_oe` drop on the edge that accepts `probe_req`.
  - `id_lcd`, `h_disp`, `v_disp`, `clk_sel` and `id_err` hold their old values until the next DECODE.
- Reset at any time:
  - FSM returns to SETTLE and all counters clear.
  - Reset values: `lcd_rgb_oe=0`, `disp_en=0`, `busy=1`, `id_valid=0`, `id_err=0`, `id_lcd=16'h0000`, `h_disp=0`, `v_disp=0`, `clk_sel=0`.
- Counter widths are sized with `$clog2` of each parameter. Parameters must be ≥1 and MATCH_N ≤ MAX_SAMPLES.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Edge 1 is the first rising edge with `rst` low.
- Happy path: `id_valid` is high after edge SETTLE_CYC + MATCH_N·SAMPLE_GAP + 1.
- Sampling: sample k is captured at edge SETTLE_CYC + k·SAMPLE_GAP.
- Timeout path: `id_valid` is high after edge SETTLE_CYC + MAX_SAMPLES·SAMPLE_GAP + 1.
- Re-probe latency is identical, counted from the edge that accepts `probe_req`.
- `lcd_rgb_oe` and `disp_en` rise on the same edge as `id_valid`.
- Decoded outputs update on that same edge and never glitch in between.
- Asynchronous reset takes effect immediately and is released synchronously by the upstream reset synchroniser.

## Test plan
Parameters for all scenarios: SETTLE_CYC=8, SAMPLE_GAP=2, MATCH_N=3, MAX_SAMPLES=8.
- Reset release, static code 001 → `id_valid` high after edge 15; `id_lcd`=0x7084, 800×480, `clk_sel`=1, `id_err`=0. `oe`/`disp_en` are 0 before edge 15 and 1 after.
- Code toggles 000/101 on samples 1–2, then holds 101 → match restarts, so `id_valid` comes after edge 8+2·5+1=19; `id_lcd`=0x1018, 1280×800, `clk_sel`=3.
- Code alternates every sample → timeout; `id_valid` after edge 8+16+1=25; `id_lcd`=0x4342, 480×272, `id_err`=1.
- Static unknown code 111 → `id_valid` after edge 15; fallback 0x4342 with `id_err`=1.
- In DONE with 0x7084, pulse `probe_req` with code 010 → `id_valid`/`oe` drop next edge and old outputs hold. Fifteen edges later: 0x7016, 1024×600, `clk_sel`=2. A second `probe_req` sent while busy is ignored.
- Assert `rst` mid-SAMPLE → all outputs return to reset values immediately. After release, the full latency of 15 is observed again.
